// File: rtl/serial_arith_pkg.sv
// Shared types and sizing helpers for the bit-serial arithmetic blocks.
package serial_arith_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } sub_state_e;

    // Bit-counter width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_sub_cell.sv
// Combinational one-bit full subtractor: d = x - y - bin, bout = borrow out.
module full_sub_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// LSB-first bit-serial subtractor, one bit per cycle over WIDTH cycles.
// Define APPROX_SUB_EN to compute the low APPROX_BITS bits without borrow propagation.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH       = DefaultWidth,
    parameter int unsigned APPROX_BITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int unsigned       CntW    = cnt_width(WIDTH);
    localparam logic [CntW-1:0]   CntLast = CntW'(WIDTH - 1);

    sub_state_e       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;

    logic cell_d, cell_bout;
    logic step_d, step_bout;

    full_sub_cell u_cell (
        .x    (sa_q[0]),
        .y    (sb_q[0]),
        .bin  (br_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

`ifdef APPROX_SUB_EN
    localparam logic [CntW-1:0] ApproxLim = CntW'(APPROX_BITS);
    logic approx_zone;

    // Low bits: XOR only, and the borrow chain restarts at bit APPROX_BITS.
    assign approx_zone = (cnt_q < ApproxLim);
    assign step_d      = approx_zone ? (sa_q[0] ^ sb_q[0]) : cell_d;
    assign step_bout   = approx_zone ? 1'b0 : cell_bout;
`else
    assign step_d    = cell_d;
    assign step_bout = cell_bout;
`endif

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
        busy    = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                busy  = 1'b1;
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                sr_d  = {step_d, sr_q[WIDTH-1:1]};
                br_d  = step_bout;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    diff_d  = {step_d, sr_q[WIDTH-1:1]};
                    bout_d  = step_bout;
                    state_d = StDone;
                end
            end
            StDone: begin
                done = 1'b1;
                // Back-to-back accept without passing through idle.
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
        end
    end

    assign diff       = diff_q;
    assign borrow_out = bout_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first two's-complement/unsigned subtractor computing diff = a - b over WIDTH clock cycles, one full-subtractor step per cycle.
- Counterpart to the combinational half-adder cell.
- Intended as the low-area difference/error unit in the approximate DNN datapath, e.g. residual and error terms.
- Optional approximate mode breaks the borrow chain in the low bits.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2).
- APPROX_BITS, 2, number of LSBs computed approximately when APPROX_SUB_EN is defined (0..WIDTH-1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; a/b sampled on the same edge when accepted.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  single-cycle pulse when diff/borrow_out become valid.
- diff  output  WIDTH  result a - b mod 2^WIDTH; held until the next accepted start.
- borrow_out  output  1  final borrow; 1 iff a < b unsigned. Held with diff.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy=0, done=0, diff=0, borrow_out=0; shift registers, bit counter and borrow all cleared.
- Reset overrides everything, including mid-RUN: the operation in progress is discarded and done is never pulsed for it.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 -> latch a into sa, b into sb; borrow=0; cnt=0; go to RUN. busy=1 from the next cycle.
- RUN, each cycle, with x=sa[0], y=sb[0], br=borrow:
  - d = x^y^br
  - br_next = (~x&y) | (~(x^y)&br)
  - diff shift register shifts right with d inserted at MSB; sa and sb shift right; cnt++.
  - When cnt==WIDTH-1, go to DONE.
- DONE (one cycle): done=1, busy=0; diff holds the full result; borrow_out = final borrow.
  - Next state is IDLE, or RUN if start=1 (back-to-back accept, new operands latched).
- Latency: start accepted at edge t -> done high in cycle t+WIDTH+1.
  - WIDTH=8: busy cycles t+1..t+8, done at t+9.
  - Throughput: one result per WIDTH+1 cycles.
- start while busy=1 is ignored; no queueing, and the in-flight result is unaffected.
- diff/borrow_out are updated only on done; between operations they hold the previous result.
  - During RUN, diff is internal shift state and must not be relied on.
- Width rules:
  - cnt is clog2(WIDTH) bits.
  - All arithmetic is modulo 2^WIDTH.
  - No sign extension; the signed interpretation of diff is the caller's.

Optional Feature:
- Macro: APPROX_SUB_EN.
- Defined: for bit positions i < APPROX_BITS, d_i = a_i ^ b_i and the borrow out of that bit is forced 0.
  - Bits >= APPROX_BITS use the exact cell with borrow_in=0 at bit APPROX_BITS.
  - borrow_out reflects only the exact upper section.
  - Latency unchanged.
- Undefined: fully exact subtraction; APPROX_BITS is unused.

Decomposition:
- Shared package serial_arith_pkg holds:
  - state enum type (IDLE/RUN/DONE);
  - localparam default WIDTH;
  - a function computing the counter width.
- One sub-module: full_sub_cell (inputs x, y, bin; outputs d, bout), purely combinational, instantiated once in the RUN datapath.
- With APPROX_SUB_EN, the approximate path is a mux around full_sub_cell selected by cnt < APPROX_BITS.

Test Plan:
- a=8'h37, b=8'h15, start pulse at t -> busy t+1..t+8; done only at t+9; diff=8'h22, borrow_out=0.
- a=8'h05, b=8'h0A -> diff=8'hFB, borrow_out=1; separately a=8'hFF, b=8'hFF -> diff=8'h00, borrow_out=0; a=8'h00, b=8'h01 -> diff=8'hFF, borrow_out=1.
- a=8'h40, b=8'h01, with start re-pulsed (a=8'h00, b=8'h00) at t+3 -> second start ignored; result diff=8'h3F at t+9.
- Back-to-back: start held high at the done cycle with a=8'h10, b=8'h08 -> immediately re-enters RUN; second done 9 cycles later with diff=8'h08; first result visible for the intervening cycles.
- rst=1 at t+4 mid-RUN -> next cycle busy=0, done=0, diff=0, borrow_out=0; no done pulse follows; a fresh op a=8'h09, b=8'h03 then yields diff=8'h06.
- APPROX_SUB_EN, APPROX_BITS=2: a=8'h10, b=8'h01 -> diff=8'h11, borrow_out=0 (exact build gives 8'h0F); exact build for the same inputs -> diff=8'h0F.
